// File: rtl/regwb_arbiter.sv
// Writeback arbiter for the register file's single write port.
// Two requesters (ALU result path, memory load path) compete for one write
// per cycle. ALU wins by default; a saturating starvation counter forces the
// load path through after STARVE_MAX consecutive lost cycles. A per-register
// pending scoreboard tracks destinations with an outstanding writeback so
// decode can stall dependent reads.
module regwb_arbiter #(
  parameter int W          = 8,
  parameter int D          = 3,
  parameter int STARVE_MAX = 3
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [D-1:0]      alu_reg,
  input  logic [W-1:0]      alu_data,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [D-1:0]      mem_reg,
  input  logic [W-1:0]      mem_data,
  input  logic              issue_valid,
  input  logic [D-1:0]      issue_reg,
  output logic [1:0]        RegWrite,
  output logic [D-1:0]      wr_reg,
  output logic [W-1:0]      writeValue,
  output logic [2**D-1:0]   pending
);

  localparam int          NREG       = 2**D;
  localparam logic [3:0]  STARVE_LIM = 4'(STARVE_MAX);

  // Registered state
  logic [3:0]      starve_q,   starve_d;
  logic [1:0]      regwrite_q, regwrite_d;
  logic [D-1:0]    wr_reg_q,   wr_reg_d;
  logic [W-1:0]    wdata_q,    wdata_d;
  logic [NREG-1:0] pending_q,  pending_d;

  // Arbitration results for the current cycle
  logic            grant_alu;
  logic            grant_mem;
  logic            grant_any;
  logic [D-1:0]    grant_reg;
  logic [W-1:0]    grant_data;

  // Grant decision: ALU priority unless the load path has starved to the limit.
  // Grants are suppressed while Reset is high so nothing looks accepted.
  always_comb begin
    grant_alu = 1'b0;
    grant_mem = 1'b0;
    if (!Reset) begin
      if (mem_valid && (!alu_valid || starve_q == STARVE_LIM)) begin
        grant_mem = 1'b1;
      end else if (alu_valid) begin
        grant_alu = 1'b1;
      end
    end
  end

  assign alu_ready = grant_alu;
  assign mem_ready = grant_mem;
  assign grant_any = grant_alu | grant_mem;

  // Select the winning request's destination and data
  always_comb begin
    grant_reg  = alu_reg;
    grant_data = alu_data;
    if (grant_mem) begin
      grant_reg  = mem_reg;
      grant_data = mem_data;
    end
  end

  // Starvation counter: count cycles the load path waits, saturating at the limit
  always_comb begin
    starve_d = 4'd0;
    if (mem_valid && !grant_mem) begin
      if (starve_q >= STARVE_LIM) begin
        starve_d = STARVE_LIM;
      end else begin
        starve_d = starve_q + 4'd1;
      end
    end
  end

  // Write port next state: pulse RegWrite=01 after a grant, hold index/data otherwise
  always_comb begin
    regwrite_d = 2'b00;
    wr_reg_d   = wr_reg_q;
    wdata_d    = wdata_q;
    if (grant_any) begin
      regwrite_d = 2'b01;
      wr_reg_d   = grant_reg;
      wdata_d    = grant_data;
    end
  end

  // Scoreboard next state per register: an issue sets the bit and takes
  // precedence over a write to the same register in the same cycle.
  for (genvar gi = 0; gi < NREG; gi++) begin : g_pending
    always_comb begin
      pending_d[gi] = pending_q[gi];
      if (grant_any && grant_reg == D'(gi)) begin
        pending_d[gi] = 1'b0;
      end
      if (issue_valid && issue_reg == D'(gi)) begin
        pending_d[gi] = 1'b1;
      end
    end
  end

  // State registers with asynchronous reset; an in-flight grant is dropped
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      starve_q   <= 4'd0;
      regwrite_q <= 2'b00;
      wr_reg_q   <= '0;
      wdata_q    <= '0;
      pending_q  <= '0;
    end else begin
      starve_q   <= starve_d;
      regwrite_q <= regwrite_d;
      wr_reg_q   <= wr_reg_d;
      wdata_q    <= wdata_d;
      pending_q  <= pending_d;
    end
  end

  assign RegWrite   = regwrite_q;
  assign wr_reg     = wr_reg_q;
  assign writeValue = wdata_q;
  assign pending    = pending_q;

endmodule
